// File: rtl/zfb_pkg.sv
// zfb_pkg: shared constants and state encoding for the frame-buffer scanout reader
package zfb_pkg;
  localparam int H_RES_DEF = 480;
  localparam int V_RES_DEF = 272;
  localparam int ADDR_W = 24;
  localparam int PIX_W = 16;
  localparam int REM_W = 18;
  localparam logic [PIX_W-1:0] BLACK = 16'h0000;
  typedef enum logic [1:0] {IDLE, FILL, WAIT, ABORT} state_t;
endpackage

// File: rtl/zfb_pixel_fifo.sv
// zfb_pixel_fifo: synchronous pixel FIFO, registered read data, flush beats push/pop
// Ports: i_push/i_din write, i_pop loads o_dout, i_flush empties, o_count/o_empty/o_full status.
module zfb_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_count;
  logic w_push;
  logic w_pop;
  assign o_count = r_count;
  assign o_empty = r_count == '0;
  assign o_full = r_count == FULL;
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop = i_pop && !o_empty && !i_flush;
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) o_dout <= '0;
    else if (w_pop) o_dout <= r_mem[r_rd];
  end
endmodule

// File: rtl/zfb_scanout_reader.sv
// zfb_scanout_reader: walks the frame buffer with single-word SDRAM reads and serves pixels to the TFT stage
// Ports: en gates new reads; iFrame_Start restarts the frame; iPixel_Req pops one pixel onto oPixel/oPixel_Valid;
// oUnderflow is sticky until the next frame start; oFrame_Done pulses after the last read;
// oSDRAM_Rd_Addr/oSDRAM_Rd_Req with iSDRAM_Rd_Data/iSDRAM_Rd_Done form the read handshake.
module zfb_scanout_reader
  import zfb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              iFrame_Start,
  input  logic              iPixel_Req,
  output logic [PIX_W-1:0]  oPixel,
  output logic              oPixel_Valid,
  output logic              oUnderflow,
  output logic              oFrame_Done,
  output logic [ADDR_W-1:0] oSDRAM_Rd_Addr,
  output logic              oSDRAM_Rd_Req,
  input  logic [PIX_W-1:0]  iSDRAM_Rd_Data,
  input  logic              iSDRAM_Rd_Done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [REM_W-1:0] TOTAL = REM_W'(H_RES * V_RES);
  state_t r_state;
  logic [REM_W-1:0] r_remaining;
  logic r_black;
  logic w_restart;
  logic w_push;
  logic w_space;
  logic [CW-1:0] w_count;
  logic w_empty;
  logic w_full;
  logic [PIX_W-1:0] w_dout;
  // A frame start in IDLE/FILL restarts at once; a mid-read start waits for the outstanding done.
  assign w_restart = iFrame_Start && ((r_state == IDLE && en) || r_state == FILL) ||
                     iSDRAM_Rd_Done && (r_state == ABORT || (r_state == WAIT && iFrame_Start));
  assign w_push = r_state == WAIT && iSDRAM_Rd_Done && !iFrame_Start && !w_full;
  assign w_space = w_count < CW'(FIFO_DEPTH);
  // oPixel is BLACK after an underflowing or flushed pop, otherwise the FIFO's registered head.
  assign oPixel = r_black ? BLACK : w_dout;
  zfb_pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (iPixel_Req),
    .i_flush (w_restart),
    .i_din   (iSDRAM_Rd_Data),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_remaining <= '0;
      oSDRAM_Rd_Addr <= ADDR_BASE;
      oSDRAM_Rd_Req <= 1'b0;
      oFrame_Done <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oFrame_Done <= 1'b0;
      if (iPixel_Req && w_empty && !w_restart) oUnderflow <= 1'b1;
      if (w_restart) begin
        oUnderflow <= 1'b0;
        oSDRAM_Rd_Addr <= ADDR_BASE;
        oSDRAM_Rd_Req <= 1'b0;
        r_remaining <= TOTAL;
        r_state <= FILL;
      end else begin
        case (r_state)
          FILL:
            if (r_remaining == '0) begin
              oFrame_Done <= 1'b1;
              r_state <= IDLE;
            end else if (en && w_space) begin
              oSDRAM_Rd_Req <= 1'b1;
              r_state <= WAIT;
            end
          WAIT:
            if (iFrame_Start) r_state <= ABORT;
            else if (iSDRAM_Rd_Done) begin
              oSDRAM_Rd_Req <= 1'b0;
              oSDRAM_Rd_Addr <= oSDRAM_Rd_Addr + ADDR_W'(1);
              r_remaining <= r_remaining - REM_W'(1);
              r_state <= FILL;
            end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oPixel_Valid <= 1'b0;
      r_black <= 1'b1;
    end else begin
      oPixel_Valid <= iPixel_Req;
      if (iPixel_Req) r_black <= w_restart || w_empty;
    end
  end
endmodule

// File: tb/tb_zfb_scanout_reader.sv
// tb_zfb_scanout_reader: scoreboard bench for the scanout reader (4x2 frame, 4-deep FIFO, base address near wrap)
module tb_zfb_scanout_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic iFrame_Start = 1'b0;
  logic iPixel_Req = 1'b0;
  logic iSDRAM_Rd_Done = 1'b0;
  logic [15:0] iSDRAM_Rd_Data = 16'h0;
  logic [15:0] oPixel;
  logic oPixel_Valid;
  logic oUnderflow;
  logic oFrame_Done;
  logic oSDRAM_Rd_Req;
  logic [23:0] oSDRAM_Rd_Addr;
  int n_vec = 0;
  int n_err = 0;
  int n_reads = 0;
  int n_done = 0;
  int done_delay = 1;
  int wait_cnt = 0;
  logic req_q = 1'b0;
  logic [15:0] exp_pix[$];
  logic [23:0] exp_addr[$];
  logic [15:0] pix_seq [7] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};

  always #5 clk = ~clk;

  zfb_scanout_reader #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4), .ADDR_BASE(24'hFFFFFE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .iFrame_Start   (iFrame_Start),
    .iPixel_Req     (iPixel_Req),
    .oPixel         (oPixel),
    .oPixel_Valid   (oPixel_Valid),
    .oUnderflow     (oUnderflow),
    .oFrame_Done    (oFrame_Done),
    .oSDRAM_Rd_Addr (oSDRAM_Rd_Addr),
    .oSDRAM_Rd_Req  (oSDRAM_Rd_Req),
    .iSDRAM_Rd_Data (iSDRAM_Rd_Data),
    .iSDRAM_Rd_Done (iSDRAM_Rd_Done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix_req(logic [15:0] e);
    exp_pix.push_back(e);
    iPixel_Req = 1'b1;
    cyc(1);
    iPixel_Req = 1'b0;
  endtask

  task automatic frame_start;
    iFrame_Start = 1'b1;
    cyc(1);
    iFrame_Start = 1'b0;
  endtask

  // Memory model: word at address A holds A[15:0]; done follows after done_delay cycles of Req.
  initial forever begin
    @(posedge clk);
    #1;
    iSDRAM_Rd_Done = 1'b0;
    if (!oSDRAM_Rd_Req) wait_cnt = 0;
    else if (wait_cnt >= done_delay) begin
      iSDRAM_Rd_Done = 1'b1;
      iSDRAM_Rd_Data = oSDRAM_Rd_Addr[15:0];
      wait_cnt = 0;
    end else wait_cnt++;
  end

  // Monitor: pops the scoreboards on every pixel strobe and every new read request.
  always @(negedge clk) begin : mon
    logic [15:0] ep;
    logic [23:0] ea;
    if (rst_n && oPixel_Valid) begin
      if (exp_pix.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pix_unexpected: got %0h with no pixel expected", oPixel);
      end else begin
        ep = exp_pix.pop_front();
        chk("pixel", {16'h0, oPixel}, {16'h0, ep});
      end
    end
    if (oSDRAM_Rd_Req && !req_q) begin
      n_reads++;
      if (exp_addr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got read at %0h with none expected", oSDRAM_Rd_Addr);
      end else begin
        ea = exp_addr.pop_front();
        chk("rd_addr", {8'h0, oSDRAM_Rd_Addr}, {8'h0, ea});
      end
    end
    req_q = oSDRAM_Rd_Req;
    if (oFrame_Done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_pixel", {16'h0, oPixel}, 32'h0);
    chk("rst_valid", {31'h0, oPixel_Valid}, 32'h0);
    chk("rst_uflow", {31'h0, oUnderflow}, 32'h0);
    chk("rst_fdone", {31'h0, oFrame_Done}, 32'h0);
    chk("rst_req", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    chk("rst_addr", {8'h0, oSDRAM_Rd_Addr}, 32'hFFFFFE);
    rst_n = 1'b1;
    cyc(2);
    // Pop before any data: BLACK and sticky underflow.
    pix_req(16'h0000);
    chk("uflow_set", {31'h0, oUnderflow}, 32'h1);
    cyc(5);
    chk("uflow_sticky", {31'h0, oUnderflow}, 32'h1);
    // Frame with no pops: exactly four reads fill the FIFO, addresses wrap.
    exp_addr.push_back(24'hFFFFFE);
    exp_addr.push_back(24'hFFFFFF);
    exp_addr.push_back(24'h000000);
    exp_addr.push_back(24'h000001);
    en = 1'b1;
    frame_start();
    chk("uflow_clear", {31'h0, oUnderflow}, 32'h0);
    cyc(30);
    chk("fill_reads", n_reads, 4);
    chk("fill_req_low", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    // One pop frees one slot: exactly one more read.
    exp_addr.push_back(24'h000002);
    pix_req(16'hFFFE);
    cyc(10);
    chk("one_more_read", n_reads, 5);
    chk("one_more_req_low", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    // Drain the rest of the frame in order.
    exp_addr.push_back(24'h000003);
    exp_addr.push_back(24'h000004);
    exp_addr.push_back(24'h000005);
    foreach (pix_seq[i]) begin
      pix_req(pix_seq[i]);
      cyc(5);
    end
    cyc(10);
    chk("frame_reads", n_reads, 8);
    chk("frame_done_once", n_done, 1);
    chk("frame_uflow", {31'h0, oUnderflow}, 32'h0);
    chk("frame_req_low", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    pix_req(16'h0000);
    chk("uflow_after_frame", {31'h0, oUnderflow}, 32'h1);
    // Frame start during a slow read: Req held, data discarded, restart at base.
    done_delay = 5;
    exp_addr.push_back(24'hFFFFFE);
    exp_addr.push_back(24'hFFFFFE);
    frame_start();
    chk("uflow_clear2", {31'h0, oUnderflow}, 32'h0);
    for (int i = 0; i < 20 && !oSDRAM_Rd_Req; i++) cyc(1);
    chk("abort_req_up", {31'h0, oSDRAM_Rd_Req}, 32'h1);
    cyc(1);
    en = 1'b0;
    frame_start();
    cyc(2);
    chk("abort_req_held", {31'h0, oSDRAM_Rd_Req}, 32'h1);
    cyc(6);
    chk("abort_req_low", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    chk("abort_reads", n_reads, 9);
    pix_req(16'h0000);
    chk("abort_fifo_empty", {31'h0, oUnderflow}, 32'h1);
    en = 1'b1;
    exp_addr.push_back(24'hFFFFFF);
    for (int i = 0; i < 40 && !(oSDRAM_Rd_Req && oSDRAM_Rd_Addr == 24'hFFFFFF); i++) cyc(1);
    chk("second_read_up", {31'h0, oSDRAM_Rd_Req}, 32'h1);
    pix_req(16'hFFFE);
    cyc(1);
    // Reset during WAIT.
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_pixel", {16'h0, oPixel}, 32'h0);
    chk("mid_rst_valid", {31'h0, oPixel_Valid}, 32'h0);
    chk("mid_rst_uflow", {31'h0, oUnderflow}, 32'h0);
    chk("mid_rst_fdone", {31'h0, oFrame_Done}, 32'h0);
    chk("mid_rst_req", {31'h0, oSDRAM_Rd_Req}, 32'h0);
    chk("mid_rst_addr", {8'h0, oSDRAM_Rd_Addr}, 32'hFFFFFE);
    rst_n = 1'b1;
    cyc(1);
    pix_req(16'h0000);
    chk("post_rst_empty", {31'h0, oUnderflow}, 32'h1);
    cyc(5);
    chk("total_reads", n_reads, 11);
    chk("total_frame_done", n_done, 1);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("pix_queue_empty", exp_pix.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
